// File: rtl/raster_pkg.sv
// Shared types for the line rasterizer: coordinate/intensity widths, the
// latched line descriptor, the FSM state encoding and the on-screen test
// used when clipping is compiled in.
package raster_pkg;

   localparam int unsigned COORD_W = 13;
   localparam int unsigned INT_W   = 4;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t             sx;
      coord_t             sy;
      coord_t             ex;
      coord_t             ey;
      logic [INT_W-1:0]   intensity;
   } line_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2
   } raster_state_t;

   // True when (x,y) lies inside a w x h screen anchored at the origin.
   function automatic logic on_screen(input coord_t x, input coord_t y,
                                      input int w, input int h);
      return (int'(x) >= 0) && (int'(x) < w) && (int'(y) >= 0) && (int'(y) < h);
   endfunction

endpackage

// File: rtl/line_rasterizer.sv
// line_rasterizer: pops one line vector at a time from a show-ahead queue and
// walks it with integer Bresenham, emitting one pixel per valid/ready
// handshake. The next entry is popped only after the current line finishes.
//
// Build option: LINE_RASTERIZER_CLIP_EN -- when defined, points outside
// [0,SCREEN_W) x [0,SCREEN_H) are walked internally (one per cycle, no
// handshake) but never raise pixValid.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   QStartX/QStartY/QEndX/QEndY   queue head endpoints (signed), QIntensity
//   empty / read                  queue empty flag / one-cycle pop pulse
//   pixX/pixY/pixIntensity        current pixel, pixValid/pixReady handshake
//   busy                          FSM not idle
//   lineDone                      pulse on the cycle the last point completes
//
// read and lineDone are decoded from registered state plus the same-cycle
// empty/pixReady inputs, because the pop and the final handshake must land in
// the cycle they are qualified in; every other output is a register.
module line_rasterizer
   import raster_pkg::*;
`ifdef LINE_RASTERIZER_CLIP_EN
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
)
`endif
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [COORD_W-1:0] QStartX,
   input  logic signed [COORD_W-1:0] QEndX,
   input  logic signed [COORD_W-1:0] QStartY,
   input  logic signed [COORD_W-1:0] QEndY,
   input  logic        [INT_W-1:0]   QIntensity,
   input  logic                      empty,
   output logic                      read,
   output logic signed [COORD_W-1:0] pixX,
   output logic signed [COORD_W-1:0] pixY,
   output logic        [INT_W-1:0]   pixIntensity,
   output logic                      pixValid,
   input  logic                      pixReady,
   output logic                      busy,
   output logic                      lineDone
);

   localparam int unsigned D_W = COORD_W + 1;
   localparam int unsigned E_W = COORD_W + 3;
   localparam coord_t      C_ONE = coord_t'(1);

   raster_state_t          r_state, w_state_nxt;
   line_t                  r_line, w_line_nxt;
   coord_t                 r_x, r_y, w_x_nxt, w_y_nxt;
   logic signed [D_W-1:0]  r_dx, r_dy, w_dx_nxt, w_dy_nxt;
   logic signed [E_W-1:0]  r_err, w_err_nxt;
   logic                   r_stepx_neg, r_stepy_neg, w_stepx_neg_nxt, w_stepy_neg_nxt;
   logic                   r_pix_valid, w_pix_valid_nxt;
   logic                   r_busy;

   logic signed [D_W-1:0]  w_diff_x, w_diff_y, w_abs_x, w_abs_y;
   logic signed [E_W-1:0]  w_e2, w_dx_ext, w_dy_ext, w_err_step;
   coord_t                 w_x_step, w_y_step;
   logic                   w_at_end, w_adv, w_pop, w_done;

   // Point visibility; without clipping every point is emitted.
   function automatic logic visible(input coord_t x, input coord_t y);
`ifdef LINE_RASTERIZER_CLIP_EN
      return on_screen(x, y, SCREEN_W, SCREEN_H);
`else
      return (x == x) && (y == y);
`endif
   endfunction

   // Setup deltas from the latched line and one Bresenham step from the current point.
   always_comb begin
      w_diff_x   = D_W'(r_line.ex) - D_W'(r_line.sx);
      w_diff_y   = D_W'(r_line.ey) - D_W'(r_line.sy);
      w_abs_x    = w_diff_x[D_W-1] ? -w_diff_x : w_diff_x;
      w_abs_y    = w_diff_y[D_W-1] ? -w_diff_y : w_diff_y;
      w_e2       = r_err <<< 1;
      w_dx_ext   = E_W'(r_dx);
      w_dy_ext   = E_W'(r_dy);
      w_err_step = r_err;
      w_x_step   = r_x;
      w_y_step   = r_y;
      // Both tests use the pre-step e2, so a diagonal step applies both.
      if (w_e2 >= w_dy_ext) begin
         w_err_step = w_err_step + w_dy_ext;
         w_x_step   = r_stepx_neg ? (r_x - C_ONE) : (r_x + C_ONE);
      end
      if (w_e2 <= w_dx_ext) begin
         w_err_step = w_err_step + w_dx_ext;
         w_y_step   = r_stepy_neg ? (r_y - C_ONE) : (r_y + C_ONE);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      w_state_nxt      = r_state;
      w_line_nxt       = r_line;
      w_x_nxt          = r_x;
      w_y_nxt          = r_y;
      w_dx_nxt         = r_dx;
      w_dy_nxt         = r_dy;
      w_err_nxt        = r_err;
      w_stepx_neg_nxt  = r_stepx_neg;
      w_stepy_neg_nxt  = r_stepy_neg;
      w_pix_valid_nxt  = r_pix_valid;
      w_pop            = 1'b0;
      w_done           = 1'b0;
      w_at_end         = (r_x == r_line.ex) && (r_y == r_line.ey);
      // A hidden point needs no handshake, so it advances unconditionally.
      w_adv            = r_pix_valid ? pixReady : 1'b1;

      case (r_state)
         IDLE: begin
            if (!empty) begin
               w_pop       = 1'b1;
               w_line_nxt  = '{sx: QStartX, sy: QStartY, ex: QEndX, ey: QEndY,
                               intensity: QIntensity};
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_dx_nxt        = w_abs_x;
            w_dy_nxt        = -w_abs_y;
            w_stepx_neg_nxt = w_diff_x[D_W-1];
            w_stepy_neg_nxt = w_diff_y[D_W-1];
            w_err_nxt       = E_W'(w_abs_x) - E_W'(w_abs_y);
            w_x_nxt         = r_line.sx;
            w_y_nxt         = r_line.sy;
            w_pix_valid_nxt = visible(r_line.sx, r_line.sy);
            w_state_nxt     = DRAW;
         end
         DRAW: begin
            if (w_adv) begin
               if (w_at_end) begin
                  w_done          = 1'b1;
                  w_pix_valid_nxt = 1'b0;
                  w_state_nxt     = IDLE;
               end else begin
                  w_err_nxt       = w_err_step;
                  w_x_nxt         = w_x_step;
                  w_y_nxt         = w_y_step;
                  w_pix_valid_nxt = visible(w_x_step, w_y_step);
               end
            end
         end
         default: begin
            w_pix_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_line      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_err       <= '0;
         r_stepx_neg <= 1'b0;
         r_stepy_neg <= 1'b0;
         r_pix_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_line      <= w_line_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_dx        <= w_dx_nxt;
         r_dy        <= w_dy_nxt;
         r_err       <= w_err_nxt;
         r_stepx_neg <= w_stepx_neg_nxt;
         r_stepy_neg <= w_stepy_neg_nxt;
         r_pix_valid <= w_pix_valid_nxt;
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

   // Gate the pop with reset so no entry is consumed while the block is held.
   assign read         = rst & w_pop;
   assign lineDone     = w_done;
   assign pixX         = r_x;
   assign pixY         = r_y;
   assign pixIntensity = r_line.intensity;
   assign pixValid     = r_pix_valid;
   assign busy         = r_busy;

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Sits directly downstream of the line register queue.
- Pops one queued vector at a time: start/end X/Y plus intensity.
- Walks the vector with integer Bresenham and emits one pixel per accepted handshake toward the framebuffer writer.
- Pops the next queue entry only after the current line's last pixel is accepted.

Parameters:
COORD_W, 13, coordinate width; coordinates are two's-complement signed
INT_W, 4, intensity width
SCREEN_W, 640, visible width in pixels; used only with CLIP_EN
SCREEN_H, 480, visible height in pixels; used only with CLIP_EN

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
QStartX  in  COORD_W  queue head start X; valid while !empty
QEndX  in  COORD_W  queue head end X
QStartY  in  COORD_W  queue head start Y
QEndY  in  COORD_W  queue head end Y
QIntensity  in  INT_W  queue head intensity
empty  in  1  queue empty
read  out  1  one-cycle pop pulse to queue
pixX  out  COORD_W  pixel X
pixY  out  COORD_W  pixel Y
pixIntensity  out  INT_W  pixel intensity (the line's latched value)
pixValid  out  1  pixel valid
pixReady  in  1  framebuffer accepts pixel
busy  out  1  high in any state other than IDLE
lineDone  out  1  one-cycle pulse when a line's last pixel is accepted

Behaviour:
- Reset (rst low, async): state=IDLE; read, pixValid, busy and lineDone are 0; pixX/pixY/pixIntensity and all internal registers are 0.
- States: IDLE, SETUP, DRAW.
- IDLE:
  - If !empty: latch all Q* inputs, assert read for exactly that cycle, go to SETUP.
  - read never asserts while empty=1.
- SETUP (1 cycle):
  - dx=|ex-sx|, dy=-|ey-sy|, stepX=sign(ex-sx), stepY=sign(ey-sy); step is +1 when the difference is 0.
  - err=dx+dy; current point=(sx,sy); go to DRAW.
  - Internal widths: dx/dy COORD_W+1 signed; err and e2 COORD_W+3 signed. No overflow is possible.
- DRAW:
  - pixValid=1 and pix* = current point (after CLIP_EN filtering, below).
  - pix* are held stable while pixValid && !pixReady.
  - On handshake, if current point == end point: pulse lineDone, return to IDLE.
  - Otherwise advance one Bresenham step, with e2=2*err:
    - if e2>=dy: err+=dy, x+=stepX;
    - if e2<=dx: err+=dx, y+=stepY;
    - both conditions may apply in the same cycle (diagonal step).
- Pixel count per line is max(|dx|,|dy|)+1; endpoints are inclusive. A zero-length line emits exactly 1 pixel.
- Latency: read asserts in cycle N; the first pixValid is in cycle N+2. With pixReady held high there is 1 pixel per cycle.
- Queue pop rule:
  - The next read comes no earlier than the cycle after lineDone.
  - Minimum gap between the last pixel of one line and the first pixel of the next is 2 idle cycles.
- pixReady is ignored when pixValid=0.
- Changes on Q* inputs after the pop have no effect on the line being drawn.
- Reset mid-line: the line is abandoned with no lineDone and no further pixels. The queue entry stays consumed and is not re-popped.

Optional Feature:
- Macro: LINE_RASTERIZER_CLIP_EN.
- Defined:
  - A point with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H does not raise pixValid.
  - The walker advances through such points internally at 1 point per cycle without waiting for pixReady.
  - lineDone still fires when the end point is reached; if the end point is clipped, it fires on the cycle that point is reached.
  - A fully off-screen line emits 0 pixels but still pops and pulses lineDone.
- Undefined: every point is emitted, with coordinates passed through unmodified as COORD_W bits.

Decomposition:
- Package raster_pkg holds:
  - COORD_W and INT_W localparams;
  - typedef coord_t (signed COORD_W);
  - typedef line_t struct {sx, sy, ex, ey, intensity};
  - enum raster_state_t {IDLE, SETUP, DRAW}.
- Single module; no sub-module. The clip compare is a small inline function in raster_pkg.

Test Plan:
- Queue head (0,0)->(3,0), intensity 5, pixReady=1 -> read pulse at cycle N; pixels (0,0),(1,0),(2,0),(3,0) at cycles N+2..N+5, all intensity 5; lineDone at N+5.
- (2,2)->(0,5), steep with negative X -> exactly 4 pixels: (2,2),(1,3),(1,4),(0,5).
- (7,7)->(7,7) -> exactly 1 pixel (7,7) plus lineDone; a second queued line pops no earlier than the cycle after lineDone.
- (0,0)->(3,3) with pixReady toggling 1,0,0,1... -> pix* stable across stall cycles; exactly 4 distinct pixels; no duplicates or drops.
- empty=1 for 20 cycles -> read=0, busy=0. Then rst low in the 2nd DRAW cycle of a 10-pixel line -> all outputs 0 immediately; after release, the next pop is the following queue entry.
- With LINE_RASTERIZER_CLIP_EN, (-2,0)->(1,0) -> pixels (0,0),(1,0) only; lineDone asserted. Line (-5,-5)->(-1,-1) -> 0 pixels, 1 read, 1 lineDone.
